// File: rtl/ripple_mon_pkg.sv
// ripple_mon_pkg: shared definitions for the ripple-count monitor.
//   - mon_state_e : tracking FSM states (ST_INIT, ST_TRACK)
//   - *_DEF       : default parameter values
//   - delta_w     : width of the modular low-field difference
//   - run_w       : width of the stability run counter
package ripple_mon_pkg;

  localparam int CNT_W_DEF    = 4;
  localparam int EXT_W_DEF    = 8;
  localparam int STABLE_N_DEF = 2;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } mon_state_e;

  // (new - acc) mod 2^CNT_W needs exactly CNT_W bits.
  function automatic int delta_w(input int cnt_w);
    return cnt_w;
  endfunction

  // The run counter saturates at STABLE_N, so it must hold 0..STABLE_N.
  function automatic int run_w(input int stable_n);
    return (stable_n < 1) ? 1 : $clog2(stable_n + 1);
  endfunction

endpackage

// File: rtl/sync_stable_filter.sv
// sync_stable_filter: two-flop synchronizer plus stability filter.
// Ports:
//   clk, reset (async, active-low)
//   cnt_in  [CNT_W] : asynchronous ripple-counter outputs
//   acc_val [CNT_W] : synchronized value offered for acceptance
//   accept          : one-cycle pulse, acc_val has been stable STABLE_N samples
module sync_stable_filter
  import ripple_mon_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int STABLE_N = STABLE_N_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [CNT_W-1:0] acc_val,
  output logic             accept
);

  localparam int             RW      = run_w(STABLE_N);
  localparam logic [RW-1:0]  RUN_TGT = RW'(STABLE_N);

  logic [CNT_W-1:0] r_s1, r_s2, r_cand;
  logic [RW-1:0]    r_run;
  // Tracks the synchronizer fill after reset: the zeros left in s1/s2 by
  // reset are not samples of cnt_in and must never form a run.
  logic [1:0]       r_fill;
  logic [RW-1:0]    w_run_nxt;
  logic             w_new;

  always_comb begin
    w_new     = (r_s2 != r_cand);
    w_run_nxt = r_run;
    if (w_new)                 w_run_nxt = RW'(1);
    else if (r_run != RUN_TGT) w_run_nxt = r_run + 1'b1;
  end

  // Fire on the cycle the run first reaches STABLE_N; a saturated run that
  // keeps matching does not fire again.
  assign accept  = r_fill[1] && (w_run_nxt == RUN_TGT) && ((r_run != RUN_TGT) || w_new);
  assign acc_val = r_s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_cand <= '0;
      r_run  <= '0;
      r_fill <= '0;
    end else begin
      r_s1   <= cnt_in;
      r_s2   <= r_s1;
      r_fill <= {r_fill[0], 1'b1};
      if (r_fill[1]) begin
        r_cand <= r_s2;
        r_run  <= w_run_nxt;
      end
    end
  end

endmodule

// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor: clean, wide, single-clock view of an async ripple counter.
// Ports:
//   clk, reset (async, active-low)
//   cnt_in [CNT_W]          : ripple-counter outputs (asynchronous)
//   clr                     : synchronous clear of ext/flags, rebaseline
//   count_out [EXT_W+CNT_W] : {ext, acc}
//   count_valid             : pulse on each accepted increment
//   wrap                    : pulse when the low field wraps
//   skip_err                : sticky, an accepted jump exceeded +1
//   ovf                     : sticky, ext wrapped from all-ones
module ripple_count_monitor
  import ripple_mon_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int EXT_W    = EXT_W_DEF,
  parameter int STABLE_N = STABLE_N_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CNT_W-1:0]       cnt_in,
  input  logic                   clr,
  output logic [EXT_W+CNT_W-1:0] count_out,
  output logic                   count_valid,
  output logic                   wrap,
  output logic                   skip_err,
  output logic                   ovf
);

  localparam int DW = delta_w(CNT_W);

  logic [CNT_W-1:0] w_acc_val;
  logic             w_accept;
  logic [DW-1:0]    w_delta;

  mon_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_acc;
  logic [EXT_W-1:0] r_ext;
  logic             r_valid, r_wrap, r_skip, r_ovf;
  logic             w_base, w_step, w_wrap_now, w_skip_now;

  sync_stable_filter #(.CNT_W(CNT_W), .STABLE_N(STABLE_N)) u_filt (
    .clk     (clk),
    .reset   (reset),
    .cnt_in  (cnt_in),
    .acc_val (w_acc_val),
    .accept  (w_accept)
  );

  assign w_delta = DW'(w_acc_val - r_acc);

  // clr takes priority over any acceptance on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_base      = 1'b0;
    w_step      = 1'b0;
    w_wrap_now  = 1'b0;
    w_skip_now  = 1'b0;
    if (clr) begin
      w_state_nxt = ST_INIT;
    end else if (w_accept) begin
      unique case (r_state)
        ST_INIT: begin
          w_base      = 1'b1;
          w_state_nxt = ST_TRACK;
        end
        ST_TRACK: begin
          if (w_delta != '0) begin
            w_step     = 1'b1;
            // A smaller new value means the low field passed through zero.
            w_wrap_now = (w_acc_val < r_acc);
            w_skip_now = (w_delta > DW'(1));
          end
        end
        default: w_state_nxt = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_INIT;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc   <= '0;
      r_ext   <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_skip  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= w_step;
      r_wrap  <= w_wrap_now;
      if (clr) begin
        r_acc  <= '0;
        r_ext  <= '0;
        r_skip <= 1'b0;
        r_ovf  <= 1'b0;
      end else begin
        if (w_base || w_step) r_acc <= w_acc_val;
        if (w_wrap_now) begin
          r_ext <= r_ext + 1'b1;
          if (&r_ext) r_ovf <= 1'b1;
        end
        if (w_skip_now) r_skip <= 1'b1;
      end
    end
  end

  assign count_out   = {r_ext, r_acc};
  assign count_valid = r_valid;
  assign wrap        = r_wrap;
  assign skip_err    = r_skip;
  assign ovf         = r_ovf;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// tb_ripple_count_monitor: directed table, hand-written corner sequences and
// randomized stimulus, all cross-checked every cycle against a sample-history
// reference model.
module tb_ripple_count_monitor;

  localparam int CW = 4;
  localparam int EW = 8;
  localparam int SN = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clr = 1'b0;
  logic [CW-1:0] cnt_in = '0;
  logic [EW+CW-1:0] count_out;
  logic          count_valid, wrap, skip_err, ovf;

  ripple_count_monitor #(.CNT_W(CW), .EXT_W(EW), .STABLE_N(SN)) dut (
    .clk         (clk),
    .reset       (reset),
    .cnt_in      (cnt_in),
    .clr         (clr),
    .count_out   (count_out),
    .count_valid (count_valid),
    .wrap        (wrap),
    .skip_err    (skip_err),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int obs_valid, obs_wrap;

  // Reference model: history of every sampled cnt_in since reset, plus the
  // extended count kept as plain integers.
  int hist[$];
  bit m_init;
  int m_acc, m_ext;
  bit m_valid, m_wrap, m_skip, m_ovf;

  typedef struct {
    int cnt;
    bit clr;
    int hold;
    int exp_cnt;
    int exp_valid;
    int exp_wrap;
    bit exp_skip;
    bit exp_ovf;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_acc  = 0;
    m_ext  = 0;
    m_skip = 0;
    m_ovf  = 0;
    m_init = 1;
  endfunction

  // A sample captured at edge i reaches the filter compare two edges later;
  // a value is accepted when its run of identical samples is exactly SN long.
  function automatic void model_edge(input int v, input bit c);
    int  e, i, len, nv, d;
    bit  acc_now;
    hist.push_back(v);
    m_valid = 0;
    m_wrap  = 0;
    acc_now = 0;
    nv      = 0;
    e = hist.size();
    if (e >= 3) begin
      i   = e - 3;
      nv  = hist[i];
      len = 1;
      while (len <= SN && (i - len) >= 0 && hist[i-len] == nv) len++;
      acc_now = (len == SN);
    end
    if (c) begin
      model_clear();
    end else if (acc_now) begin
      if (m_init) begin
        m_acc  = nv;
        m_init = 0;
      end else begin
        d = (nv - m_acc) & ((1 << CW) - 1);
        if (d != 0) begin
          m_valid = 1;
          if (nv < m_acc) begin
            m_wrap = 1;
            if (m_ext == (1 << EW) - 1) m_ovf = 1;
            m_ext = (m_ext + 1) % (1 << EW);
          end
          if (d > 1) m_skip = 1;
          m_acc = nv;
        end
      end
    end
  endfunction

  task automatic step(input int v, input bit c);
    logic [EW+CW+3:0] act, exp;
    logic [31:0] e32, a32;
    cnt_in = v[CW-1:0];
    clr    = c;
    @(posedge clk);
    model_edge(v, c);
    #1;
    a32 = m_acc;
    e32 = m_ext;
    act = {count_out, count_valid, wrap, skip_err, ovf};
    exp = {e32[EW-1:0], a32[CW-1:0], m_valid, m_wrap, m_skip, m_ovf};
    check("cycle_vs_model", 32'(act), 32'(exp));
    obs_valid += int'(count_valid);
    obs_wrap  += int'(wrap);
    clr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({count_out, count_valid, wrap, skip_err, ovf}), 32'h0);
    hist.delete();
    model_clear();
    m_valid = 0;
    m_wrap  = 0;
    reset = 1'b1;
  endtask

  function automatic void add(input int c, input bit k, input int h, input int ec,
                              input int ev, input int ew, input bit es, input bit eo);
    vec_t t;
    t.cnt = c; t.clr = k; t.hold = h; t.exp_cnt = ec;
    t.exp_valid = ev; t.exp_wrap = ew; t.exp_skip = es; t.exp_ovf = eo;
    tbl.push_back(t);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, v, h, wraps_seen;
    bit c, ovf_at_wrap;

    // cnt, clr, hold, count_out, valid pulses, wrap pulses, skip, ovf
    add(5, 0, 10, 'h005, 0, 0, 0, 0);   // baseline, no pulse
    add(6, 0, 10, 'h006, 1, 0, 0, 0);
    add(7, 0, 10, 'h007, 1, 0, 0, 0);
    for (int k = 8; k <= 15; k++) add(k, 0, 4, k, 1, 0, 0, 0);
    add(0, 0, 4, 'h010, 1, 1, 0, 0);    // low field wraps into ext
    add(1, 0, 4, 'h011, 1, 0, 0, 0);
    add(1, 1, 1, 'h000, 0, 0, 0, 0);    // clr
    add(3, 0, 5, 'h003, 0, 0, 0, 0);    // new baseline after clr
    add(15, 0, 1, 'h003, 0, 0, 0, 0);   // single-sample glitch
    add(9, 0, 6, 'h009, 1, 0, 1, 0);    // glitch dropped, jump of 6
    add(4, 0, 3, 'h009, 0, 0, 1, 0);    // acceptance lands on next edge
    add(4, 1, 1, 'h000, 0, 0, 0, 0);    // clr coincides with acceptance
    add(4, 0, 4, 'h000, 0, 0, 0, 0);    // saturated run: no re-accept
    add(6, 0, 4, 'h006, 0, 0, 0, 0);    // next stable value is baseline
    add(7, 0, 4, 'h007, 1, 0, 0, 0);

    do_reset();

    foreach (tbl[n]) begin
      obs_valid = 0;
      obs_wrap  = 0;
      for (int j = 0; j < tbl[n].hold; j++) step(tbl[n].cnt, tbl[n].clr && (j == 0));
      check($sformatf("tbl%0d_count", n), 32'(count_out), 32'(tbl[n].exp_cnt));
      check($sformatf("tbl%0d_valid_pulses", n), 32'(obs_valid), 32'(tbl[n].exp_valid));
      check($sformatf("tbl%0d_wrap_pulses", n), 32'(obs_wrap), 32'(tbl[n].exp_wrap));
      check($sformatf("tbl%0d_skip", n), 32'(skip_err), 32'(tbl[n].exp_skip));
      check($sformatf("tbl%0d_ovf", n), 32'(ovf), 32'(tbl[n].exp_ovf));
    end

    // Drive ext up to all-ones: each 8 -> 0 pair wraps once.
    for (int k = 0; k < 255; k++) begin
      repeat (4) step(8, 0);
      repeat (4) step(0, 0);
    end
    check("ext_full_count", 32'(count_out), 32'h0FF0);
    check("ext_full_ovf", 32'(ovf), 32'h0);
    repeat (4) step(15, 0);
    check("ext_full_acc15", 32'(count_out), 32'h0FFF);
    wraps_seen  = 0;
    ovf_at_wrap = 0;
    for (int j = 0; j < 4; j++) begin
      step(0, 0);
      if (wrap) begin
        wraps_seen++;
        ovf_at_wrap = ovf;
        check("ovf_wrap_count_out", 32'(count_out), 32'h000);
      end
    end
    check("ovf_wrap_pulses", 32'(wraps_seen), 32'd1);
    check("ovf_with_wrap", 32'(ovf_at_wrap), 32'd1);
    repeat (4) step(1, 0);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // Randomized: mix of +1 steps, arbitrary jumps, short glitches, clr
    // and one mid-run reset.
    prev = 1;
    for (int it = 0; it < 300; it++) begin
      if (it == 150) do_reset();
      v = ($urandom_range(0, 1) == 0) ? (prev + 1) % 16 : int'($urandom_range(0, 15));
      h = $urandom_range(1, 5);
      c = ($urandom_range(0, 19) == 0);
      for (int j = 0; j < h; j++) step(v, c && (j == 0));
      prev = v;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ripple_count_monitor.md
# ripple_count_monitor

Synchronous monitor downstream of the 4-bit asynchronous ripple up-counter. It samples the counter's asynchronous outputs into the `clk` domain and filters ripple glitches by requiring a stable value. It extends the 4-bit count with an overflow-tracked upper field and flags skipped increments. It feeds system logic that needs a clean, wide, single-clock count.

## Interface
- `CNT_W`, 4: width of the monitored ripple count.
- `EXT_W`, 8: width of the wrap-extension field.
- `STABLE_N`, 2: consecutive identical synchronized samples required to accept a value (≥1).

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low; all state cleared while low.
- `cnt_in` in CNT_W: ripple-counter outputs, asynchronous to `clk`.
- `clr` in 1: synchronous clear. Clears the extension and flags, then rebaselines.
- `count_out` out EXT_W+CNT_W: `{ext, acc}`, the accepted extended count.
- `count_valid` out 1: one-cycle pulse when a new value is accepted.
- `wrap` out 1: one-cycle pulse when the accepted low field wraps.
- `skip_err` out 1: sticky; set on any accepted jump greater than +1.
- `ovf` out 1: sticky; set when `ext` wraps from all-ones to 0.

## Operation
- Two-flop synchronizer per bit: `cnt_in` → `s1` → `s2`.
- Stability filter:
  - `cand` holds the last `s2` value; `run` counts consecutive cycles with `s2 == cand`.
  - When `s2 != cand`: load `cand = s2` and set `run = 1`.
  - The value is accepted when `run` reaches `STABLE_N`. It is accepted once per stable run; `run` saturates.
- FSM states:
  - INIT (reset/clr state): the first accepted value loads `acc` as the baseline. `ext` stays 0 and no pulses are issued. Then go to TRACK.
  - TRACK: compute `delta = (new − acc) mod 2^CNT_W` on each acceptance.
    - `delta == 0`: no action.
    - `delta == 1`: set `acc = new` and pulse `count_valid`. If `new < acc`, pulse `wrap` and increment `ext`.
    - `delta > 1`: same update as `delta == 1`, and also set `skip_err`. A wrap is implied when `new < acc`.
- `ext` wraps modulo 2^EXT_W. When it wraps, set `ovf`.
- `clr`:
  - Sets `acc`, `ext`, `skip_err` and `ovf` to 0.
  - Moves the FSM to INIT. Synchronizer and filter contents are kept, so a stable value is re-accepted as the baseline once `run` reaches `STABLE_N` again.
  - If an acceptance coincides with `clr`, `clr` wins.

## Timing
- Reset values: `count_out = 0`, `count_valid = 0`, `wrap = 0`, `skip_err = 0`, `ovf = 0`, FSM = INIT, `s1`/`s2`/`cand`/`run` = 0.
- Latency: `cnt_in` stable before edge k is captured into `s1` at edge k. `count_out`, `count_valid` and `wrap` update at edge k+1+STABLE_N. With the defaults, that is edge k+3.
- Glitch handling: a `cnt_in` value held for fewer than STABLE_N+1 edges may be dropped. The next accepted value then shows `delta > 1` and sets `skip_err`. This is intended; no value is ever accepted from a sample run shorter than STABLE_N.
- `count_valid` and `wrap` are high for exactly one cycle. `wrap` is always coincident with `count_valid`.
- `reset` deassertion mid-operation: the FSM restarts in INIT, and the first post-reset accepted value is the baseline.

## Structure
- Package `ripple_mon_pkg` holds:
  - the FSM state enum (`ST_INIT`, `ST_TRACK`);
  - default parameter constants;
  - the `delta` width function.
- Sub-module `sync_stable_filter` (parameters `CNT_W`, `STABLE_N`) contains the synchronizer, `cand` and `run`. Its outputs are `acc_val` and a one-cycle `accept` pulse.
- The top level contains the FSM, the `ext` field, and the flags.

## Test plan
- Reset low, then high, with `cnt_in = 5` held: at edge 3, `count_out = 0x005`, no `count_valid`, FSM in TRACK.
- Baseline 5, then step `cnt_in` 6 → 7, each held 10 cycles: `count_valid` pulses 3 edges after each change; `count_out` = 0x006, then 0x007; `skip_err = 0`.
- Count 14 → 15 → 0 → 1: `wrap` pulses on acceptance of 0 and `count_out = 0x010`; after 1, `count_out = 0x011`.
- Baseline 3, jump `cnt_in` to 9; also apply a 1-cycle glitch to 0xF: the glitch is not accepted, `count_out = 0x009`, `skip_err = 1`.
- `ext = 0xFF` with `acc = 15`, then `cnt_in = 0`: `count_out = 0x000`, `wrap = 1` and `ovf = 1` on the same cycle.
- Assert `clr` on the same edge as a pending acceptance: all fields and flags are 0, FSM is INIT, no `count_valid`, and the next stable value becomes the baseline.
